// File: rtl/wide_add_sequencer_if.sv
// Operand/result handshake bundle for the wide add/subtract sequencer.
interface wide_add_sequencer_if #(
  parameter int WORDS = 4
);
  logic                  start_valid;
  logic                  start_ready;
  logic [32*WORDS-1:0]   a;
  logic [32*WORDS-1:0]   b;
  logic                  sub;
  logic                  res_valid;
  logic                  res_ready;
  logic [32*WORDS-1:0]   result;
  logic                  carry_out;
  logic                  overflow;
  logic                  busy;

  modport master (
    output start_valid, a, b, sub, res_ready,
    input  start_ready, res_valid, result, carry_out, overflow, busy
  );

  modport slave (
    input  start_valid, a, b, sub, res_ready,
    output start_ready, res_valid, result, carry_out, overflow, busy
  );
endinterface

// File: rtl/wide_add_sequencer.sv
// Multi-precision add/sub: one 32-bit limb per cycle through a shared adder,
// carry chained through a register; result valid WORDS cycles after accept.
module thirtyTwo_bit_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};
endmodule

module wide_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  wide_add_sequencer_if.slave   bus
);
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q;
  logic [IW-1:0]         idx_q;
  logic                  carry_q;
  logic [32*WORDS-1:0]   a_q;
  logic [32*WORDS-1:0]   b_q;
  logic                  sub_q;
  logic [32*WORDS-1:0]   result_q;
  logic                  carry_out_q;
  logic                  overflow_q;
  logic                  start_ready_q;
  logic                  res_valid_q;
  logic                  busy_q;

  logic [31:0]           a_limb;
  logic [31:0]           b_limb;
  logic [31:0]           sum_limb;
  logic                  cout_limb;
  logic                  last_limb;
  logic                  ovf_limb;

  always_comb begin
    a_limb = '0;
    b_limb = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (idx_q == IW'(k)) begin
        a_limb = a_q[32*k +: 32];
        b_limb = sub_q ? ~b_q[32*k +: 32] : b_q[32*k +: 32];
      end
    end
  end

  thirtyTwo_bit_adder u_adder (
    .a    (a_limb),
    .b    (b_limb),
    .cin  (carry_q),
    .sum  (sum_limb),
    .cout (cout_limb)
  );

  assign last_limb = (idx_q == IW'(WORDS - 1));
  // Signed overflow only matters on the top limb, where bit 31 is the sign.
  assign ovf_limb  = (a_limb[31] == b_limb[31]) && (sum_limb[31] != a_limb[31]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      carry_q       <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      sub_q         <= 1'b0;
      result_q      <= '0;
      carry_out_q   <= 1'b0;
      overflow_q    <= 1'b0;
      start_ready_q <= 1'b1;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_valid && start_ready_q) begin
            a_q           <= bus.a;
            b_q           <= bus.b;
            sub_q         <= bus.sub;
            idx_q         <= '0;
            carry_q       <= bus.sub;
            state_q       <= RUN;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b1;
          end
        end
        RUN: begin
          for (int k = 0; k < WORDS; k++) begin
            if (idx_q == IW'(k)) result_q[32*k +: 32] <= sum_limb;
          end
          carry_q <= cout_limb;
          if (last_limb) begin
            carry_out_q <= cout_limb;
            overflow_q  <= ovf_limb;
            state_q     <= DONE;
            res_valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            state_q       <= IDLE;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            start_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.start_ready = start_ready_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.busy        = busy_q;
  assign bus.result      = result_q;
  assign bus.carry_out   = carry_out_q;
  assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed vector bench for wide_add_sequencer (WORDS=4, 128-bit operands).
module tb_wide_add_sequencer;
  localparam int WORDS = 4;
  localparam int W     = 32 * WORDS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  wide_add_sequencer_if #(.WORDS(WORDS)) bus ();

  wide_add_sequencer #(.WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t vecs [8];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    int guard;
    guard = 0;
    while (!bus.start_ready && guard < 20) begin
      step;
      guard++;
    end
    chk("start_ready_before_accept", W'(bus.start_ready), W'(1));
    bus.a           = a;
    bus.b           = b;
    bus.sub         = sub;
    bus.start_valid = 1'b1;
    step;
    bus.start_valid = 1'b0;
    // Scramble inputs during RUN; they must not influence the result.
    bus.a   = ~a;
    bus.b   = ~b;
    bus.sub = ~sub;
    chk("busy_after_accept", W'(bus.busy), W'(1));
    chk("start_ready_in_run", W'(bus.start_ready), W'(0));
    chk("res_valid_in_run", W'(bus.res_valid), W'(0));
  endtask

  task automatic wait_result(output int cyc);
    cyc = 0;
    while (!bus.res_valid && cyc < 20) begin
      step;
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    logic stray;
    logic [W-1:0] ones;
    ones = '1;

    vecs[0] = '{128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'd1, 1'b0,
                128'h0000_0000_0000_0000_0000_0001_0000_0000, 1'b0, 1'b0};
    vecs[1] = '{ones, 128'd1, 1'b0, 128'd0, 1'b1, 1'b0};
    vecs[2] = '{128'd0, 128'd1, 1'b1, ones, 1'b0, 1'b0};
    vecs[3] = '{128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0,
                128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b1};
    vecs[4] = '{128'h8000_0000_0000_0000_0000_0000_0000_0000, 128'd1, 1'b1,
                128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs[5] = '{128'd10, 128'd3, 1'b1, 128'd7, 1'b1, 1'b0};
    vecs[6] = '{ones, ones, 1'b0,
                128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0};
    vecs[7] = '{128'h0000_0001_FFFF_FFFF_0000_0000_FFFF_FFFF,
                128'h0000_0000_0000_0001_0000_0000_0000_0001, 1'b0,
                128'h0000_0002_0000_0000_0000_0001_0000_0000, 1'b0, 1'b0};

    bus.start_valid = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.sub         = 1'b0;
    bus.res_ready   = 1'b0;

    rst = 1'b1;
    step;
    step;
    rst = 1'b0;
    step;
    chk("rst_start_ready", W'(bus.start_ready), W'(1));
    chk("rst_res_valid", W'(bus.res_valid), W'(0));
    chk("rst_busy", W'(bus.busy), W'(0));
    chk("rst_result", bus.result, '0);
    chk("rst_carry_out", W'(bus.carry_out), W'(0));
    chk("rst_overflow", W'(bus.overflow), W'(0));

    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].sub);
      // Odd vectors hold res_ready high throughout RUN, where it must be ignored.
      bus.res_ready = (i % 2) == 1;
      wait_result(cyc);
      chk($sformatf("v%0d_latency", i), W'(cyc), W'(WORDS));
      chk($sformatf("v%0d_result", i), bus.result, vecs[i].res);
      chk($sformatf("v%0d_carry_out", i), W'(bus.carry_out), W'(vecs[i].co));
      chk($sformatf("v%0d_overflow", i), W'(bus.overflow), W'(vecs[i].ov));
      bus.res_ready = 1'b1;
      step;
      bus.res_ready = 1'b0;
      chk($sformatf("v%0d_idle_ready", i), W'(bus.start_ready), W'(1));
      chk($sformatf("v%0d_idle_valid", i), W'(bus.res_valid), W'(0));
      chk($sformatf("v%0d_idle_busy", i), W'(bus.busy), W'(0));
      chk($sformatf("v%0d_retained", i), bus.result, vecs[i].res);
    end

    // Backpressure: DONE held for 5 cycles while the producer misbehaves.
    start_op(128'd5, 128'd7, 1'b0);
    wait_result(cyc);
    chk("bp_latency", W'(cyc), W'(WORDS));
    for (int j = 0; j < 5; j++) begin
      bus.start_valid = (j % 2) == 0;
      bus.a           = W'($urandom);
      bus.b           = W'($urandom);
      step;
      chk($sformatf("bp%0d_result", j), bus.result, 128'd12);
      chk($sformatf("bp%0d_start_ready", j), W'(bus.start_ready), W'(0));
      chk($sformatf("bp%0d_res_valid", j), W'(bus.res_valid), W'(1));
    end
    bus.start_valid = 1'b0;
    bus.res_ready   = 1'b1;
    step;
    bus.res_ready   = 1'b0;
    chk("bp_release_ready", W'(bus.start_ready), W'(1));
    chk("bp_release_valid", W'(bus.res_valid), W'(0));
    chk("bp_release_result", bus.result, 128'd12);

    // Reset while the index is 2 in RUN.
    start_op(128'h1111_1111_1111_1111_1111_1111_1111_1111,
             128'h2222_2222_2222_2222_2222_2222_2222_2222, 1'b0);
    step;
    step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("mid_rst_start_ready", W'(bus.start_ready), W'(1));
    chk("mid_rst_res_valid", W'(bus.res_valid), W'(0));
    chk("mid_rst_busy", W'(bus.busy), W'(0));
    chk("mid_rst_result", bus.result, '0);
    chk("mid_rst_carry_out", W'(bus.carry_out), W'(0));
    chk("mid_rst_overflow", W'(bus.overflow), W'(0));
    stray = 1'b0;
    for (int j = 0; j < 8; j++) begin
      step;
      if (bus.res_valid) stray = 1'b1;
    end
    chk("mid_rst_no_res_valid", W'(stray), W'(0));

    // Recovery after the aborted operation.
    start_op(vecs[0].a, vecs[0].b, vecs[0].sub);
    wait_result(cyc);
    chk("recover_latency", W'(cyc), W'(WORDS));
    chk("recover_result", bus.result, vecs[0].res);
    bus.res_ready = 1'b1;
    step;
    bus.res_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
Multi-precision add/subtract sequencer that computes a WORDS×32-bit sum or difference. It uses a single instance of the team's thirtyTwo_bit_adder, one 32-bit limb per clock, and chains the carry through a register between limbs. It sits between an operand producer and a result consumer, with a valid/ready handshake on each side. It is the controller that time-shares the 32-bit adder datapath for wide arithmetic.

Parameters:
WORDS, 4, number of 32-bit limbs; operand width = 32*WORDS; legal range 1..16.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
start_valid  input  1  operands and op are valid.
start_ready  output  1  block can accept operands (high only in IDLE).
a  input  32*WORDS  operand A, unsigned/two's-complement.
b  input  32*WORDS  operand B.
sub  input  1  0 = A+B, 1 = A-B.
res_valid  output  1  result, carry_out and overflow are valid.
res_ready  input  1  consumer accepts the result.
result  output  32*WORDS  sum/difference, modulo 2^(32*WORDS).
carry_out  output  1  carry out of the top limb (for sub: 1 = no borrow).
overflow  output  1  signed overflow of the full-width operation.
busy  output  1  high in RUN or DONE.

Behaviour:
- Reset is synchronous, active-high, and has priority over everything else, including an operation in progress.
- On reset: state=IDLE, start_ready=1, res_valid=0, busy=0, result=0, carry_out=0, overflow=0, limb index=0, carry register=0.
- FSM states IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On the edge where start_valid&&start_ready: latch a, b, sub; index<=0; carry<=sub; go to RUN.
- RUN:
  - Adder inputs: A=a_q[32k+:32], B=(sub_q ? ~b_q[32k+:32] : b_q[32k+:32]), cin=carry register.
  - Each edge: result[32k+:32]<=adder sum; carry<=adder cout; k<=k+1.
  - On the edge that processes k=WORDS-1:
    - carry_out<=adder cout.
    - overflow<=(A[31]==B'[31]) && (sum[31]!=A[31]), where B' is the inverted-if-sub limb.
    - go to DONE.
- DONE:
  - res_valid=1.
  - result, carry_out and overflow are held stable until res_valid&&res_ready; on that edge go to IDLE.
- Latency: res_valid first high exactly WORDS cycles after the accepting edge. With WORDS=1, res_valid is high the cycle after acceptance.
- Throughput: one operation per WORDS+2 cycles minimum. A new start is accepted no earlier than the cycle after the result handshake; start_ready=0 in RUN and DONE.
- Input stability: a, b, sub and start_valid are ignored outside IDLE. Changes to them during RUN do not affect the result.
- res_ready is ignored while res_valid=0.
- Register visibility: result limbs are written progressively during RUN, and consumers must only sample them when res_valid=1. result, carry_out and overflow are retained in IDLE until the next operation overwrites them or reset clears them.
- Reset mid-operation: the operation is aborted and no res_valid is produced for it. The next cycle is IDLE with start_ready=1 and all outputs zero.
- Index counter width: clog2(WORDS), minimum 1 bit. It never exceeds WORDS-1.

Test Plan:
- Reset, then idle: rst high 2 cycles, then low -> start_ready=1, res_valid=0, busy=0, result=0, carry_out=0, overflow=0.
- Carry ripple across limbs (WORDS=4): a=0x0000_0000_0000_0000_0000_0000_FFFF_FFFF, b=1, sub=0 -> exactly 4 cycles after accept:
  - res_valid=1, result=0x0000_0000_0000_0000_0000_0001_0000_0000, carry_out=0, overflow=0.
- Full wrap: a=all ones (128-bit), b=1, sub=0 -> result=0, carry_out=1, overflow=0.
- Subtract with borrow: a=0, b=1, sub=1 -> result=all ones, carry_out=0, overflow=0.
- Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, b=1, sub=0 -> result=0x8000_0000_0000_0000_0000_0000_0000_0000, carry_out=0, overflow=1.
- Backpressure and reset: hold res_ready=0 for 5 cycles in DONE while toggling start_valid and changing a/b -> result stays stable, start_ready=0, no new accept. Then pulse res_ready -> IDLE next cycle.
  - Separately, assert rst while the index is 2 in RUN -> next cycle IDLE, res_valid never rises, result=0, start_ready=1.
